// File: rtl/mux_pkg.sv
// Shared definitions for the N:1 registered selector.
// Mode encoding and a small wrap-around helper used by the round-robin pointer.
package mux_pkg;

  typedef enum logic {
    MODE_FIXED = 1'b0,
    MODE_RR    = 1'b1
  } mux_mode_e;

  // Index of the channel after c, wrapping from n-1 back to 0.
  function automatic int wrap_inc(input int c, input int n);
    return (c + 1 >= n) ? 0 : c + 1;
  endfunction

endpackage

// File: rtl/mux_nx1_rr_if.sv
// Handshake bundle between N producers, the selector and one consumer.
// The master modport is the producer/consumer side; the slave modport is the selector.
interface mux_nx1_rr_if
  import mux_pkg::*;
#(
  parameter int N     = 4,
  parameter int WIDTH = 8
);
  localparam int SELW = $clog2(N);

  logic [N*WIDTH-1:0] din;
  logic [N-1:0]       din_valid;
  logic [N-1:0]       din_ready;
  logic [SELW-1:0]    sel;
  mux_mode_e          mode;
  logic [WIDTH-1:0]   y;
  logic               y_valid;
  logic [SELW-1:0]    y_ch;
  logic               y_ready;

  modport master (
    output din, din_valid, sel, mode, y_ready,
    input  din_ready, y, y_valid, y_ch
  );

  modport slave (
    input  din, din_valid, sel, mode, y_ready,
    output din_ready, y, y_valid, y_ch
  );

endinterface

// File: rtl/mux_rr_pick.sv
// Wrapped priority search: first valid channel at or after ptr, wrapping N-1 -> 0.
// Purely combinational; found is low when no channel is valid.
module mux_rr_pick #(
  parameter int N    = 4,
  parameter int SELW = $clog2(N)
) (
  input  logic [N-1:0]    valid,
  input  logic [SELW-1:0] ptr,
  output logic            found,
  output logic [SELW-1:0] idx
);

  int k;

  // Walk offsets from farthest to nearest so the nearest valid channel wins.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    k     = 0;
    for (int i = N - 1; i >= 0; i--) begin
      k = int'(ptr) + i;
      if (k >= N) begin
        k = k - N;
      end
      if (valid[k]) begin
        found = 1'b1;
        idx   = SELW'(k);
      end
    end
  end

endmodule

// File: rtl/mux_nx1_rr.sv
// N-channel WIDTH-bit selector with registered output and valid/ready on every side.
// Fixed mode follows sel; round-robin mode scans valid channels starting at ptr.
module mux_nx1_rr
  import mux_pkg::*;
#(
  parameter int N     = 4,
  parameter int WIDTH = 8
) (
  input logic          clk,
  input logic          rst,
  mux_nx1_rr_if.slave  bus
);

  localparam int SELW = $clog2(N);

  logic             ld;
  logic             grant;
  logic             sel_ok;
  logic             rr_found;
  logic [SELW-1:0]  rr_idx;
  logic             cand_found;
  logic [SELW-1:0]  cand_idx;
  logic             cand_valid;
  logic [WIDTH-1:0] cand_data;
  logic [N-1:0]     din_ready_c;

  logic [SELW-1:0]  ptr;
  logic [WIDTH-1:0] y_q;
  logic             y_valid_q;
  logic [SELW-1:0]  y_ch_q;

  mux_rr_pick #(
    .N    (N),
    .SELW (SELW)
  ) u_pick (
    .valid (bus.din_valid),
    .ptr   (ptr),
    .found (rr_found),
    .idx   (rr_idx)
  );

  // A select value can only be out of range when N is not a power of two.
  if ((1 << SELW) == N) begin : g_sel_full
    assign sel_ok = 1'b1;
  end else begin : g_sel_partial
    assign sel_ok = (bus.sel < SELW'(N));
  end

  always_comb begin
    cand_found = 1'b0;
    cand_idx   = '0;
    if (bus.mode == MODE_RR) begin
      cand_found = rr_found;
      cand_idx   = rr_idx;
    end else begin
      cand_found = sel_ok;
      cand_idx   = bus.sel;
    end
  end

  always_comb begin
    cand_valid = 1'b0;
    cand_data  = '0;
    for (int k = 0; k < N; k++) begin
      if (cand_idx == SELW'(k)) begin
        cand_valid = bus.din_valid[k];
        cand_data  = bus.din[k*WIDTH +: WIDTH];
      end
    end
  end

  assign ld    = !rst && (!y_valid_q || bus.y_ready);
  assign grant = ld && cand_found && cand_valid;

  // Ready goes to the candidate whenever we could load, even if it is not valid.
  always_comb begin
    din_ready_c = '0;
    for (int k = 0; k < N; k++) begin
      if (ld && cand_found && (cand_idx == SELW'(k))) begin
        din_ready_c[k] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      y_q       <= '0;
      y_valid_q <= 1'b0;
      y_ch_q    <= '0;
      ptr       <= '0;
    end else if (ld) begin
      if (grant) begin
        y_q       <= cand_data;
        y_ch_q    <= cand_idx;
        y_valid_q <= 1'b1;
        if (bus.mode == MODE_RR) begin
          ptr <= SELW'(wrap_inc(int'(cand_idx), N));
        end
      end else begin
        y_valid_q <= 1'b0;
      end
    end
  end

  assign bus.din_ready = din_ready_c;
  assign bus.y         = y_q;
  assign bus.y_valid   = y_valid_q;
  assign bus.y_ch      = y_ch_q;

endmodule

// File: tb/tb_mux_nx1_rr.sv
// Scoreboard bench for mux_nx1_rr: a 4-channel instance driven cycle by cycle
// against a reference model, plus a 3-channel instance for the out-of-range select.
module tb_mux_nx1_rr;
  import mux_pkg::*;

  localparam int N = 4;
  localparam int W = 8;

  logic clk;
  logic rst;
  logic rst3;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  mux_nx1_rr_if #(.N(4), .WIDTH(8)) bus4 ();
  mux_nx1_rr_if #(.N(3), .WIDTH(8)) bus3 ();

  mux_nx1_rr #(.N(4), .WIDTH(8)) dut4 (
    .clk (clk),
    .rst (rst),
    .bus (bus4.slave)
  );

  mux_nx1_rr #(.N(3), .WIDTH(8)) dut3 (
    .clk (clk),
    .rst (rst3),
    .bus (bus3.slave)
  );

  int         n_checks = 0;
  int         n_errors = 0;
  logic [9:0] sb[$];
  logic [7:0] din_arr[N];
  int         m_ptr = 0;
  logic       m_yvalid = 1'b0;
  logic       m_known = 1'b0;
  logic       m_rst_prev = 1'b0;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  // One clock cycle: drive at the falling edge, check, then advance the model.
  task automatic applyStimulus(input logic r, input logic [3:0] v, input logic m,
                               input logic [1:0] s, input logic yr);
    logic       ld;
    logic       cfound;
    logic       grant;
    int         c;
    logic [3:0] exp_rdy;
    @(negedge clk);
    rst            = r;
    bus4.din       = {din_arr[3], din_arr[2], din_arr[1], din_arr[0]};
    bus4.din_valid = v;
    bus4.mode      = m ? MODE_RR : MODE_FIXED;
    bus4.sel       = s;
    bus4.y_ready   = yr;
    #1;
    if (m_known) begin
      checkOutput("y_valid", 32'(bus4.y_valid), 32'(m_yvalid));
      if (m_rst_prev) begin
        checkOutput("rst_y", 32'(bus4.y), 32'h0);
        checkOutput("rst_y_ch", 32'(bus4.y_ch), 32'h0);
      end
      if (m_yvalid) begin
        checkOutput("sb_depth", 32'(sb.size()), 32'd1);
        if (sb.size() > 0) begin
          checkOutput("y_ch", 32'(bus4.y_ch), 32'(sb[0][9:8]));
          checkOutput("y", 32'(bus4.y), 32'(sb[0][7:0]));
        end
      end
    end

    ld     = !r && (!m_yvalid || yr);
    cfound = 1'b0;
    c      = 0;
    if (m) begin
      for (int i = 0; i < N; i++) begin
        int k = (m_ptr + i) % N;
        if (!cfound && v[k]) begin
          cfound = 1'b1;
          c      = k;
        end
      end
    end else begin
      cfound = 1'b1;
      c      = int'(s);
    end
    exp_rdy = (ld && cfound) ? (4'b0001 << c) : 4'b0000;
    if (m_known || r) begin
      checkOutput("din_ready", 32'(bus4.din_ready), 32'(exp_rdy));
    end
    grant = ld && cfound && v[c];

    if (m_yvalid && yr && sb.size() > 0) begin
      void'(sb.pop_front());
    end
    if (r) begin
      sb.delete();
      m_yvalid = 1'b0;
      m_ptr    = 0;
      m_known  = 1'b1;
    end else if (ld) begin
      if (grant) begin
        sb.push_back({2'(c), din_arr[c]});
        m_yvalid = 1'b1;
        if (m) begin
          m_ptr = (c + 1) % N;
        end
      end else begin
        m_yvalid = 1'b0;
      end
    end
    m_rst_prev = r;
  endtask

  initial begin
    rst            = 1'b1;
    rst3           = 1'b1;
    bus4.din       = '0;
    bus4.din_valid = '0;
    bus4.mode      = MODE_FIXED;
    bus4.sel       = '0;
    bus4.y_ready   = 1'b0;
    bus3.din       = {8'h22, 8'h21, 8'h20};
    bus3.din_valid = 3'b111;
    bus3.mode      = MODE_FIXED;
    bus3.sel       = 2'd3;
    bus3.y_ready   = 1'b1;
    for (int k = 0; k < N; k++) din_arr[k] = 8'h10 + 8'(k);
    din_arr[2] = 8'hA5;

    // Reset with every channel valid, then fixed select of channel 2.
    repeat (2) applyStimulus(1'b1, 4'b1111, 1'b0, 2'd2, 1'b1);
    repeat (3) applyStimulus(1'b0, 4'b1111, 1'b0, 2'd2, 1'b1);

    // Round-robin with all valid; ptr must still be 0 after fixed mode.
    din_arr[2] = 8'h12;
    repeat (5) applyStimulus(1'b0, 4'b1111, 1'b1, 2'd0, 1'b1);

    // Sparse valids from ptr=0, then starvation, then confirm ptr wrapped to 0.
    applyStimulus(1'b1, 4'b0000, 1'b1, 2'd0, 1'b1);
    repeat (4) applyStimulus(1'b0, 4'b1010, 1'b1, 2'd0, 1'b1);
    repeat (2) applyStimulus(1'b0, 4'b0000, 1'b1, 2'd0, 1'b1);
    applyStimulus(1'b0, 4'b1111, 1'b1, 2'd0, 1'b1);
    applyStimulus(1'b0, 4'b0000, 1'b1, 2'd0, 1'b1);

    // Backpressure stall, resume, then reset while a word is held.
    applyStimulus(1'b1, 4'b1111, 1'b1, 2'd0, 1'b1);
    applyStimulus(1'b0, 4'b1111, 1'b1, 2'd0, 1'b1);
    repeat (3) applyStimulus(1'b0, 4'b1111, 1'b1, 2'd0, 1'b0);
    applyStimulus(1'b0, 4'b1111, 1'b1, 2'd0, 1'b1);
    applyStimulus(1'b1, 4'b1111, 1'b1, 2'd0, 1'b0);
    applyStimulus(1'b0, 4'b1111, 1'b1, 2'd0, 1'b1);
    applyStimulus(1'b0, 4'b0000, 1'b1, 2'd0, 1'b1);

    // Random traffic, including mode/sel changes during stalls.
    for (int i = 0; i < 80; i++) begin
      for (int k = 0; k < N; k++) din_arr[k] = 8'($urandom);
      applyStimulus(1'b0, 4'($urandom), 1'($urandom), 2'($urandom), ($urandom_range(0, 3) != 0));
    end
    applyStimulus(1'b0, 4'b0000, 1'b0, 2'd0, 1'b1);
    applyStimulus(1'b0, 4'b0000, 1'b0, 2'd0, 1'b1);

    // Three-channel instance: sel=3 has no candidate, sel=1 grants channel 1.
    @(negedge clk);
    rst3 = 1'b0;
    #1;
    checkOutput("n3_ready_oor", 32'(bus3.din_ready), 32'h0);
    @(negedge clk);
    #1;
    checkOutput("n3_y_valid_oor", 32'(bus3.y_valid), 32'h0);
    checkOutput("n3_ready_oor2", 32'(bus3.din_ready), 32'h0);
    bus3.sel = 2'd1;
    #1;
    checkOutput("n3_ready_sel1", 32'(bus3.din_ready), 32'h2);
    @(negedge clk);
    #1;
    checkOutput("n3_y_valid", 32'(bus3.y_valid), 32'h1);
    checkOutput("n3_y_ch", 32'(bus3.y_ch), 32'h1);
    checkOutput("n3_y", 32'(bus3.y), 32'h21);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/mux_nx1_rr.md
Name: mux_nx1_rr

Overview:
- Parametrised N-channel, WIDTH-bit selector with a registered output and valid/ready handshakes on every input and on the output.
- Two modes:
  - Fixed: the channel is picked by `sel`.
  - Round-robin: fair scan over the channels that are currently valid.
- Sits between multiple producers and one downstream consumer, giving 1-cycle latency at full throughput.

Parameters:
- N, 4, number of input channels (N >= 2).
- WIDTH, 8, data width per channel.
- SELW, $clog2(N), select/channel-index width (localparam, derived, not overridable).

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- din  input  N*WIDTH  flattened channel data; channel k occupies bits [k*WIDTH +: WIDTH].
- din_valid  input  N  per-channel valid.
- din_ready  output  N  per-channel ready; combinational, one-hot or zero.
- sel  input  SELW  channel select, used in fixed mode only.
- mode  input  1  0 = fixed, 1 = round-robin.
- y  output  WIDTH  registered output data.
- y_valid  output  1  output holds a word.
- y_ch  output  SELW  index of the channel that supplied y.
- y_ready  input  1  consumer accepts y this cycle.

Behaviour:
- Reset (rst=1 at a clock edge):
  - y=0, y_valid=0, y_ch=0, rr pointer ptr=0.
  - din_ready=0 for the whole cycle rst is high.
  - Reset mid-transfer drops the held word with no flush.
- Load enable: `ld = !rst && (!y_valid || y_ready)`.
- Candidate channel c:
  - Fixed mode: c = sel. If sel >= N (possible only when N is not a power of 2), there is no candidate.
  - RR mode: c is the first k with din_valid[k]=1, searching from ptr upward and wrapping N-1 -> 0.
  - RR mode with no valid channel: no candidate.
- Grant: grant = ld && candidate exists && din_valid[c].
  - din_ready[c] = ld && candidate exists, so ready may be high in fixed mode while valid is low.
  - All other din_ready bits are 0.
- On grant, at the next edge: y <= din[c], y_ch <= c, y_valid <= 1.
- When ld=1 and there is no grant: y_valid <= 0. y and y_ch keep their last values.
- When ld=0 (stalled, y_valid && !y_ready): y, y_valid and y_ch hold; all din_ready=0.
- Pointer:
  - On an RR-mode grant only, ptr <= (c == N-1) ? 0 : c+1.
  - ptr is unchanged in fixed mode and on cycles with no grant.
  - ptr is retained across mode changes.
- Timing:
  - Latency is 1 cycle from grant to y_valid.
  - Throughput is one word per cycle while y_ready=1.
  - Simultaneous consume and load in the same cycle is required (y_valid stays 1 back-to-back).
- sel/mode changes during a stall take effect at the next cycle with ld=1. They never alter a held word.
- Input channels must hold din/din_valid until their ready is seen; the block does not check this.

Decomposition:
- Shared package `mux_pkg`: MODE_FIXED=1'b0, MODE_RR=1'b1.
- One sub-module, `mux_rr_pick` (combinational):
  - Inputs: valid[N], ptr[SELW].
  - Outputs: found, idx[SELW].
  - Implements the wrapped priority search.
- Top level holds the ptr register, the output register and the handshake logic.

Test Plan (N=4, WIDTH=8 unless stated):
- Reset: rst=1 for 2 cycles with all din_valid=1 -> y=8'h00, y_valid=0, y_ch=0, din_ready=4'b0000 throughout.
- Fixed: mode=0, sel=2, din_valid=4'b1111, ch2=8'hA5, y_ready=1 -> din_ready=4'b0100 each cycle. Next edge: y=8'hA5, y_ch=2, y_valid=1. ptr stays 0.
- RR all valid: mode=1, din_valid=4'b1111, ch k data = 8'h10+k, y_ready=1 -> y_ch sequence 0,1,2,3,0 and y = 10,11,12,13,10 on consecutive cycles.
- RR sparse: din_valid=4'b1010 from ptr=0 -> y_ch sequence 1,3,1,3. Then drop to din_valid=4'b0000 -> y_valid=0 the cycle after the last consume, ptr unchanged.
- Backpressure/reset: RR all valid, capture ch0, then y_ready=0 for 3 cycles.
  - During the stall: y=8'h10, y_ch=0 held, din_ready=4'b0000.
  - Raise y_ready: the next word is ch1.
  - Assert rst while y_valid=1: next edge y_valid=0, ptr=0.
- Out-of-range sel: instance N=3 (SELW=2), mode=0, sel=3, din_valid=3'b111 -> din_ready=3'b000, y_valid stays 0. Switching to sel=1 grants ch1 on the next edge.
